ussub_stream_ctrl: RTL

// - Job sequencer for one uSSUB unary scaled subtractor: takes binary operands A,B, runs 2^BW-cycle unary streams, returns binary count of output ones.
// - Result approximates (A + N - B)/2, N = 2^BW; bipolar difference scaled by 1/2.
// - Sits between binary butterfly control and the unary datapath; one job in flight at a time.

---
 rtl/ussub_ctrl_pkg.sv | 26 ++
 rtl/ussub.sv | 38 +++
 rtl/ussub_bitgen.sv | 35 +++
 rtl/ussub_stream_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/ussub_ctrl_pkg.sv
// Shared types and helpers for the uSSUB stream controller.
// Sequencer states, default sizing and the stream bit-reversal helper.
package ussub_ctrl_pkg;

  localparam int unsigned DEF_BW      = 8;
  localparam int unsigned DEF_SUB_LAT = 2;
  localparam int unsigned N           = 1 << DEF_BW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Reverse the low w bits of v; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) begin
      r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ussub.sv
// Unary scaled subtractor: emits ones at rate (a + (1-b))/2 using a 1-bit residue.
// Residue is only cleared by reset, so rounding carries between jobs.
module ussub #(
  parameter int unsigned SUB_LAT = 2
) (
  input  logic iClk,
  input  logic iRstN,
  input  logic iA,
  input  logic iB,
  output logic oC
);

  logic [SUB_LAT-2:0] a_sr;
  logic [SUB_LAT-2:0] nb_sr;
  logic               acc_q;
  logic [1:0]         sum;

  assign sum = {1'b0, acc_q} + {1'b0, a_sr[SUB_LAT-2]} + {1'b0, nb_sr[SUB_LAT-2]};

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      a_sr  <= '0;
      nb_sr <= '0;
      acc_q <= 1'b0;
      oC    <= 1'b0;
    end else begin
      a_sr[0]  <= iA;
      nb_sr[0] <= ~iB;
      for (int unsigned i = 1; i < SUB_LAT - 1; i++) begin
        a_sr[i]  <= a_sr[i-1];
        nb_sr[i] <= nb_sr[i-1];
      end
      oC    <= sum[1];
      acc_q <= sum[0];
    end
  end

endmodule

// File: rtl/ussub_bitgen.sv
// Stream position counter and unary bit generators for both operands.
// B uses the bit-reversed position so the two streams stay decorrelated.
module ussub_bitgen
  import ussub_ctrl_pkg::*;
#(
  parameter int unsigned BW = 8
) (
  input  logic          iClk,
  input  logic          iRstN,
  input  logic          en,
  input  logic          clr,
  input  logic [BW-1:0] a_q,
  input  logic [BW-1:0] b_q,
  output logic          bitA,
  output logic          bitB,
  output logic          last
);

  logic [BW-1:0] cnt_q;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + BW'(1);
    end
  end

  assign bitA = (a_q > cnt_q);
  assign bitB = (32'(b_q) > bitrev(32'(cnt_q), BW));
  assign last = (cnt_q == '1);

endmodule

// File: rtl/ussub_stream_ctrl.sv
// Job sequencer for one uSSUB: runs 2^BW-cycle unary streams and counts output ones.
// One job in flight; result held in DONE until consumed.
module ussub_stream_ctrl
  import ussub_ctrl_pkg::*;
#(
  parameter int unsigned BW      = 8,
  parameter int unsigned SUB_LAT = 2
) (
  input  logic          iClk,
  input  logic          iRstN,
  input  logic          iValid,
  output logic          oReady,
  input  logic [BW-1:0] iA,
  input  logic [BW-1:0] iB,
  input  logic          iAbort,
  output logic          oValid,
  input  logic          iReady,
  output logic [BW:0]   oRes,
  output logic          oBusy
);

  localparam int unsigned DW = (SUB_LAT < 2) ? 1 : $clog2(SUB_LAT);

  state_t        st_q, st_d;
  logic          accept;
  logic [BW-1:0] a_q, b_q;
  logic [BW:0]   ones_q;
  logic [DW-1:0] dcnt_q;
  logic          run, counting;
  logic          bit_a, bit_b, last;
  logic          sub_a, sub_b, sub_c;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) st_q <= ST_IDLE;
    else        st_q <= st_d;
  end

  // Abort outranks accept and consume in the same cycle.
  always_comb begin
    st_d   = st_q;
    accept = 1'b0;
    if (iAbort) begin
      st_d = ST_IDLE;
    end else begin
      unique case (st_q)
        ST_IDLE: if (iValid) begin
          st_d   = ST_RUN;
          accept = 1'b1;
        end
        ST_RUN:   if (last) st_d = ST_DRAIN;
        ST_DRAIN: if (dcnt_q == DW'(SUB_LAT - 1)) st_d = ST_DONE;
        ST_DONE:  if (iReady) st_d = ST_IDLE;
        default:  st_d = ST_IDLE;
      endcase
    end
  end

  assign run      = (st_q == ST_RUN);
  assign counting = run || (st_q == ST_DRAIN);
  assign oReady   = (st_q == ST_IDLE);
  assign oValid   = (st_q == ST_DONE);
  assign oBusy    = counting;
  assign oRes     = ones_q;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      a_q    <= '0;
      b_q    <= '0;
      ones_q <= '0;
      dcnt_q <= '0;
    end else begin
      if (accept) begin
        a_q <= iA;
        b_q <= iB;
      end
      if (iAbort || accept)             ones_q <= '0;
      else if (counting && sub_c)       ones_q <= ones_q + (BW+1)'(1);
      if (!iAbort && st_q == ST_DRAIN)  dcnt_q <= dcnt_q + DW'(1);
      else                              dcnt_q <= '0;
    end
  end

  ussub_bitgen #(.BW(BW)) u_bitgen (
    .iClk  (iClk),
    .iRstN (iRstN),
    .en    (run),
    .clr   (accept | iAbort),
    .a_q   (a_q),
    .b_q   (b_q),
    .bitA  (bit_a),
    .bitB  (bit_b),
    .last  (last)
  );

  // Outside RUN the subtractor sees A=0, B=1, which adds no ones.
  assign sub_a = run ? bit_a : 1'b0;
  assign sub_b = run ? bit_b : 1'b1;

  ussub #(.SUB_LAT(SUB_LAT)) u_ussub (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iA    (sub_a),
    .iB    (sub_b),
    .oC    (sub_c)
  );

endmodule
